simple_ff_async: RTL and testbench

SIMPLE_FF_ASYNC -- requirements
Module: simple_ff_async

---
 rtl/simple_ff_async.sv | 79 +++++++
 tb/tb_simple_ff_async.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/simple_ff_async.sv
// simple_ff_async
//   Single-bit output register with an optional input synchronizer.
//
//   Parameters
//     ASYNC       "TRUE"  : D is asynchronous and passes through a
//                           SYNC_STAGES-deep flop chain before the output reg.
//                 "FALSE" : D is already synchronous to CK and feeds Q directly.
//     SYNC_STAGES synchronizer depth, 2..4 (ignored when ASYNC="FALSE").
//
//   Ports
//     CK  in  rising-edge clock for all state
//     SR  in  synchronous active-high reset (or set, see macro below)
//     CE  in  clock enable for the output register only
//     D   in  data input
//     Q   out registered data output, driven directly by a flop
//
//   Configuration macro
//     SIMPLE_FF_ASYNC_SET_EN  defined   : SR loads 1 into Q and all sync stages
//                             undefined : SR loads 0 (default build)
module simple_ff_async #(
  parameter string       ASYNC       = "TRUE",
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CK,
  input  logic SR,
  input  logic CE,
  input  logic D,
  output logic Q
);

`ifdef SIMPLE_FF_ASYNC_SET_EN
  localparam logic RST_VAL = 1'b1;
`else
  localparam logic RST_VAL = 1'b0;
`endif

  // Reject illegal configurations at elaboration.
  generate
    if (!((ASYNC == "TRUE") || (ASYNC == "FALSE"))) begin : g_bad_async
      $error("simple_ff_async: ASYNC must be \"TRUE\" or \"FALSE\"");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_stages
      $error("simple_ff_async: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  generate
    if (ASYNC == "TRUE") begin : g_sync
      // Pure shift chain, no logic between stages; clocked every edge so a
      // low CE never leaves stale data in the chain.
      (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;

      always_ff @(posedge CK) begin
        if (SR) begin
          sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
          sync <= {sync[SYNC_STAGES-2:0], D};
        end
      end

      always_ff @(posedge CK) begin
        if (SR) begin
          Q <= RST_VAL;
        end else if (CE) begin
          Q <= sync[SYNC_STAGES-1];
        end
      end
    end else begin : g_direct
      always_ff @(posedge CK) begin
        if (SR) begin
          Q <= RST_VAL;
        end else if (CE) begin
          Q <= D;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_simple_ff_async.sv
// Directed self-checking bench for simple_ff_async. Three instances share
// the inputs: synchronized depth 2, synchronized depth 3, and direct.
module tb_simple_ff_async;

`ifdef SIMPLE_FF_ASYNC_SET_EN
  localparam logic RV = 1'b1;
`else
  localparam logic RV = 1'b0;
`endif

  logic CK, SR, CE, D;
  logic q_s2, q_s3, q_dir;
  int   checks, errors;

  simple_ff_async #(.ASYNC("TRUE"), .SYNC_STAGES(2)) u_s2 (
    .CK(CK), .SR(SR), .CE(CE), .D(D), .Q(q_s2));
  simple_ff_async #(.ASYNC("TRUE"), .SYNC_STAGES(3)) u_s3 (
    .CK(CK), .SR(SR), .CE(CE), .D(D), .Q(q_s3));
  simple_ff_async #(.ASYNC("FALSE"), .SYNC_STAGES(2)) u_dir (
    .CK(CK), .SR(SR), .CE(CE), .D(D), .Q(q_dir));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e2, input logic e3,
                           input logic ed);
    check({tag, "_s2"}, q_s2, e2);
    check({tag, "_s3"}, q_s3, e3);
    check({tag, "_dir"}, q_dir, ed);
  endtask

  task automatic flush0();
    SR = 1'b0; CE = 1'b1; D = 1'b0;
    for (int unsigned i = 0; i < 5; i++) tick();
  endtask

  // Expected Q per edge after D sampled 1 for one edge then 0.
  logic [4:0] pul_s2  = 5'b00100;  // bit 0 = first edge
  logic [4:0] pul_s3  = 5'b01000;
  logic [4:0] pul_dir = 5'b00001;
  // Expected Q per edge with D held 1.
  logic [3:0] hld_s2  = 4'b1100;
  logic [3:0] hld_s3  = 4'b1000;
  logic [3:0] hld_dir = 4'b1111;

  initial begin
    checks = 0;
    errors = 0;
    SR = 1'b0; CE = 1'b0; D = 1'b0;
    #2;

    // Reset before anything else, CE=0, D=0.
    SR = 1'b1;
    tick();
    check_all("reset", RV, RV, RV);
    SR = 1'b0;

    flush0();
    check_all("flush", 1'b0, 1'b0, 1'b0);

    // CE low: a one-cycle D pulse never reaches Q.
    CE = 1'b0; D = 1'b1;
    tick();
    D = 1'b0;
    check_all("ce0_pulse_0", 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("ce0_pulse_%0d", i + 1), 1'b0, 1'b0, 1'b0);
    end

    // One-cycle D pulse with CE=1: latency 1 / 3 / 4 edges.
    CE = 1'b1; D = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      D = 1'b0;
      check_all($sformatf("pulse_e%0d", i + 1), pul_s2[i], pul_s3[i], pul_dir[i]);
    end

    // D held high: sync2 rises on the 3rd edge, not earlier.
    D = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("hold_e%0d", i + 1), hld_s2[i], hld_s3[i], hld_dir[i]);
    end

    // SR wins over CE with D=1; chain is cleared and must refill.
    SR = 1'b1; CE = 1'b1; D = 1'b1;
    tick();
    check_all("sr_ce", RV, RV, RV);
    SR = 1'b0;
    tick(); check_all("refill_e1", RV, RV, 1'b1);
    tick(); check_all("refill_e2", RV, RV, 1'b1);
    tick(); check_all("refill_e3", 1'b1, RV, 1'b1);
    tick(); check_all("refill_e4", 1'b1, 1'b1, 1'b1);

    // Input changes between edges have no effect on Q.
    SR = 1'b1; CE = 1'b0; D = 1'b0;
    #3;
    check_all("midcycle", 1'b1, 1'b1, 1'b1);
    SR = 1'b0; CE = 1'b1; D = 1'b1;
    tick();
    check_all("midcycle_edge", 1'b1, 1'b1, 1'b1);

    // CE low while D rises and settles; first CE=1 edge loads the new value.
    flush0();
    CE = 1'b0; D = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("ce_wait_%0d", i + 1), 1'b0, 1'b0, 1'b0);
    end
    CE = 1'b1;
    tick();
    check_all("ce_rise", 1'b1, 1'b1, 1'b1);

    // CE low holds Q; on re-enable the current (not stale) stage is loaded.
    CE = 1'b0; D = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("ce_hold_%0d", i + 1), 1'b1, 1'b1, 1'b1);
    end
    CE = 1'b1;
    tick();
    check_all("ce_reload", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
